// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared state encoding and opcode constants for the ALU logic sequencer
package alu_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEL  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_SEL  = S_SEL,
    ST_CAPT = S_CAPT,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - 4-bit load/decrement counter that times the selector settle window
module settle_counter
  import alu_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at zero so a lingering decrement can never wrap to 15.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/alu_logic_sequencer.sv
// rtl/alu_logic_sequencer.sv - start/done sequencer driving the logic-result select stage
module alu_logic_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_sel_data,
  output logic [1:0]        o_mux_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_flag_n,
  output logic              o_flag_z,
  output logic              o_flag_v
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("alu_logic_sequencer: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_capture;
  logic   w_cnt_zero;
  logic [1:0] r_op_q;

  settle_counter u_settle_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (i_flush),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_dec      (r_state == ST_SEL),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = ST_SEL;
        end
      end
      ST_SEL: begin
        if (w_cnt_zero) w_next = ST_CAPT;
      end
      ST_CAPT: begin
        w_capture = 1'b1;
        w_next    = ST_DONE;
      end
      ST_DONE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = ST_SEL;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (i_flush) begin
      w_next    = ST_IDLE;
      w_accept  = 1'b0;
      w_capture = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // op_q doubles as the selector flop, so mux_sel comes straight off a register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_q <= OP_AND;
    end else if (w_accept) begin
      r_op_q <= i_op;
    end else if (w_next == ST_IDLE) begin
      r_op_q <= OP_AND;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result <= '0;
      o_flag_n <= 1'b0;
      o_flag_z <= 1'b0;
      o_flag_v <= 1'b0;
    end else if (w_capture) begin
      o_result <= i_sel_data;
      o_flag_n <= i_sel_data[DATA_W-1];
      o_flag_z <= (i_sel_data == '0);
      o_flag_v <= 1'b0;
    end
  end

  assign o_mux_sel = r_op_q;
  assign o_busy    = (r_state == ST_SEL) || (r_state == ST_CAPT);
  assign o_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_logic_sequencer.sv
// tb/tb_alu_logic_sequencer.sv - directed-vector bench for alu_logic_sequencer
module tb_alu_logic_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] sel_data;

  logic [1:0]  mux1, mux3;
  logic        busy1, busy3, done1, done3;
  logic [31:0] res1, res3;
  logic        n1, z1, v1, n3, z3, v3;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  alu_logic_sequencer #(.DATA_W(32), .SETTLE_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_flush(flush),
    .i_sel_data(sel_data), .o_mux_sel(mux1), .o_busy(busy1), .o_done(done1),
    .o_result(res1), .o_flag_n(n1), .o_flag_z(z1), .o_flag_v(v1)
  );

  alu_logic_sequencer #(.DATA_W(32), .SETTLE_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_flush(flush),
    .i_sel_data(sel_data), .o_mux_sel(mux3), .o_busy(busy3), .o_done(done3),
    .o_result(res3), .o_flag_n(n3), .o_flag_z(z3), .o_flag_v(v3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; sel_data = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    start = 1'b1; op = 2'b11; sel_data = 32'hDEAD_BEEF;
    step();
    start = 1'b0;
    vectors++; if (busy3 !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b exp 1", busy3); end
    vectors++; if (mux3 !== 2'b11) begin errors++; $display("FAIL rst_pre_mux: got %b exp 11", mux3); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({mux3, busy3, done3} !== 4'b0000) begin errors++; $display("FAIL rst_async: got %b exp 0000", {mux3, busy3, done3}); end
    step();
    rst_n = 1'b1;
    step();
    vectors++; if ({mux3, busy3, done3, n3, z3, v3} !== 7'b0) begin errors++; $display("FAIL rst_idle_ctl: got %b exp 0000000", {mux3, busy3, done3, n3, z3, v3}); end
    vectors++; if (res3 !== 32'h0) begin errors++; $display("FAIL rst_idle_result: got %h exp 00000000", res3); end
    vectors++; if ({mux1, busy1, done1, n1, z1, v1} !== 7'b0 || res1 !== 32'h0) begin errors++; $display("FAIL rst_idle_dut1: got %b/%h exp 0", {mux1, busy1, done1, n1, z1, v1}, res1); end
  endtask

  task automatic test_and_zero();
    do_reset();
    start = 1'b1; op = 2'b00; sel_data = 32'h0000_0000;
    step();
    start = 1'b0;
    vectors++; if ({mux1, busy1, done1} !== 4'b0010) begin errors++; $display("FAIL and_c1: got %b exp 0010", {mux1, busy1, done1}); end
    step();
    vectors++; if ({busy1, done1} !== 2'b10) begin errors++; $display("FAIL and_c2: got %b exp 10", {busy1, done1}); end
    step();
    vectors++; if ({busy1, done1} !== 2'b01) begin errors++; $display("FAIL and_c3_done: got %b exp 01", {busy1, done1}); end
    vectors++; if (res1 !== 32'h0 || {n1, z1, v1} !== 3'b010) begin errors++; $display("FAIL and_c3_flags: got %h nzv=%b exp 00000000 nzv=010", res1, {n1, z1, v1}); end
    step();
    vectors++; if ({mux1, busy1, done1} !== 4'b0000) begin errors++; $display("FAIL and_c4_idle: got %b exp 0000", {mux1, busy1, done1}); end
  endtask

  task automatic test_nor_settle3();
    do_reset();
    start = 1'b1; op = 2'b11; sel_data = 32'h8000_0001;
    step();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      vectors++; if (mux3 !== 2'b11) begin errors++; $display("FAIL nor_mux_c%0d: got %b exp 11", c, mux3); end
      vectors++; if (done3 !== (c == 5)) begin errors++; $display("FAIL nor_done_c%0d: got %b exp %b", c, done3, (c == 5)); end
      if (c < 5) step();
    end
    vectors++; if (res3 !== 32'h8000_0001 || {n3, z3, v3} !== 3'b100) begin errors++; $display("FAIL nor_flags: got %h nzv=%b exp 80000001 nzv=100", res3, {n3, z3, v3}); end
    step();
    vectors++; if ({mux3, done3} !== 3'b000) begin errors++; $display("FAIL nor_c6_idle: got %b exp 000", {mux3, done3}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start = 1'b1; op = 2'b01; sel_data = 32'h0000_00F0;
    step();
    vectors++; if ({mux1, busy1} !== 3'b011) begin errors++; $display("FAIL b2b_c1: got %b exp 011", {mux1, busy1}); end
    step();
    step();
    vectors++; if ({done1, mux1} !== 3'b101 || res1 !== 32'h0000_00F0) begin errors++; $display("FAIL b2b_first_done: got %b/%h exp 101/000000f0", {done1, mux1}, res1); end
    op = 2'b10; sel_data = 32'h0000_000F;
    step();
    start = 1'b0;
    vectors++; if ({mux1, busy1, done1} !== 4'b1010) begin errors++; $display("FAIL b2b_no_bubble: got %b exp 1010", {mux1, busy1, done1}); end
    step();
    vectors++; if ({busy1, done1} !== 2'b10) begin errors++; $display("FAIL b2b_capt: got %b exp 10", {busy1, done1}); end
    step();
    vectors++; if (done1 !== 1'b1 || res1 !== 32'h0000_000F || {n1, z1, v1} !== 3'b000) begin errors++; $display("FAIL b2b_second_done: got %b/%h nzv=%b exp 1/0000000f nzv=000", done1, res1, {n1, z1, v1}); end
  endtask

  task automatic test_ignore_start();
    int dones;
    do_reset();
    start = 1'b1; op = 2'b01; sel_data = 32'h1234_5678;
    step();
    start = 1'b0; op = 2'b10;
    dones = done3 ? 1 : 0;
    step();
    start = 1'b1;
    vectors++; if (mux3 !== 2'b01) begin errors++; $display("FAIL ign_mux_c2: got %b exp 01", mux3); end
    step();
    start = 1'b0;
    vectors++; if (mux3 !== 2'b01) begin errors++; $display("FAIL ign_mux_c3: got %b exp 01", mux3); end
    for (int c = 3; c <= 10; c++) begin
      if (done3) dones++;
      if (c == 5) begin
        vectors++; if (done3 !== 1'b1 || res3 !== 32'h1234_5678) begin errors++; $display("FAIL ign_done_c5: got %b/%h exp 1/12345678", done3, res3); end
      end
      step();
    end
    vectors++; if (dones !== 1) begin errors++; $display("FAIL ign_done_count: got %0d exp 1", dones); end
  endtask

  task automatic test_flush();
    do_reset();
    start = 1'b1; op = 2'b00; sel_data = 32'h0000_00FF;
    step();
    start = 1'b0;
    step();
    step();
    vectors++; if (done1 !== 1'b1 || res1 !== 32'h0000_00FF) begin errors++; $display("FAIL fl_prior: got %b/%h exp 1/000000ff", done1, res1); end
    step();
    start = 1'b1; op = 2'b11; sel_data = 32'h0000_0000;
    step();
    start = 1'b0;
    step();
    vectors++; if (busy1 !== 1'b1) begin errors++; $display("FAIL fl_in_capt: got %b exp 1", busy1); end
    flush = 1'b1; start = 1'b1;
    step();
    flush = 1'b0; start = 1'b0;
    vectors++; if ({mux1, busy1, done1} !== 4'b0000) begin errors++; $display("FAIL fl_idle: got %b exp 0000", {mux1, busy1, done1}); end
    vectors++; if (res1 !== 32'h0000_00FF || {n1, z1, v1} !== 3'b000) begin errors++; $display("FAIL fl_hold: got %h nzv=%b exp 000000ff nzv=000", res1, {n1, z1, v1}); end
    step();
    vectors++; if (done1 !== 1'b0) begin errors++; $display("FAIL fl_no_done: got %b exp 0", done1); end
    start = 1'b1; flush = 1'b1; op = 2'b01;
    step();
    start = 1'b0; flush = 1'b0;
    vectors++; if ({mux1, busy1} !== 3'b000) begin errors++; $display("FAIL fl_start_drop: got %b exp 000", {mux1, busy1}); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; sel_data = '0;
    test_reset();
    test_and_zero();
    test_nor_settle3();
    test_back_to_back();
    test_ignore_start();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
